vga_port_feeder: RTL

Autonomous port-write sequencer that feeds the VGA control block's PicoBlaze-style port bus (`write_strobe`/`id_port`/`dato`). On a refresh request it snapshots the current BCD date, time, chronometer, format and cursor fields. It then emits the full, fixed sequence of nibble writes to ports 0x04–0x18, followed by a handshake pulse on port 0x19. It sits directly upstream of the VGA control block, so display refreshes do not consume processor cycles.

---
 rtl/vga_port_feeder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_port_feeder.sv
`default_nettype none
// ============================================================================
// Module : vga_port_feeder
// Desc   : Snapshots BCD date/time/chrono fields on a refresh request and
//          streams them as nibble port writes (0x04-0x18) plus a 0x19
//          handshake. Optional macro VGA_FEEDER_SKIP_UNCHANGED_EN skips
//          writes whose data matches the last value sent.
// Rev    : 1.0
// ============================================================================

module vga_port_feeder #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       reloj_nexys,
  input  logic       reset_total,
  input  logic       start,
  input  logic [7:0] agno,
  input  logic [7:0] messe,
  input  logic [7:0] giorno,
  input  logic [7:0] h_oro,
  input  logic [7:0] m_oro,
  input  logic [7:0] s_oro,
  input  logic [7:0] H_run,
  input  logic [7:0] M_run,
  input  logic [7:0] S_run,
  input  logic       tempo,
  input  logic       formatto,
  input  logic [2:0] dir_cursor,
  input  logic [7:0] direccion_prog,
  output logic       write_strobe,
  output logic [7:0] id_port,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [4:0] c_LAST_IDX  = 5'd22;
  localparam logic [4:0] c_NIB_COUNT = 5'd18;
  localparam bit         c_HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [3:0] c_GAP_LAST  = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic        pend_q, pend_d;

  logic [71:0] snap_time_q;
  logic        snap_tempo_q;
  logic        snap_fmt_q;
  logic [2:0]  snap_cur_q;
  logic [7:0]  snap_prog_q;

  logic        write_strobe_q;
  logic [7:0]  id_port_q;
  logic [7:0]  dato_q;
  logic        busy_q;
  logic        done_q;

  logic [71:0] w_shift;
  logic [7:0]  w_port;
  logic [7:0]  w_dato;
  logic        w_skip;
  logic        w_issue;
  logic        w_snap;

  // Current write's port/data, derived from the snapshot and the write index.
  assign w_shift = snap_time_q << {idx_q, 2'b00};

  always_comb begin
    w_port = 8'h19;
    w_dato = 8'h00;
    if (idx_q < c_NIB_COUNT) begin
      w_port = 8'h04 + {3'b000, idx_q};
      w_dato = {4'h0, w_shift[71:68]};
    end else begin
      case (idx_q)
        5'd18: begin
          w_port = 8'h16;
          w_dato = {3'b000, snap_tempo_q, 3'b000, snap_fmt_q};
        end
        5'd19: begin
          w_port = 8'h17;
          w_dato = {5'b00000, snap_cur_q};
        end
        5'd20: begin
          w_port = 8'h18;
          w_dato = snap_prog_q;
        end
        5'd21: begin
          w_port = 8'h19;
          w_dato = 8'h01;
        end
        default: begin
          w_port = 8'h19;
          w_dato = 8'h00;
        end
      endcase
    end
  end

`ifdef VGA_FEEDER_SKIP_UNCHANGED_EN
  localparam logic [4:0] c_LAST_SHADOW = 5'd20;

  logic [20:0][7:0] shadow_q;
  logic [20:0]      shadow_vld_q;
  logic             w_in_shadow;

  assign w_in_shadow = (idx_q <= c_LAST_SHADOW);
  assign w_skip      = (state_q == ST_SEND) && w_in_shadow &&
                       shadow_vld_q[idx_q] && (shadow_q[idx_q] == w_dato);

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      shadow_q     <= '0;
      shadow_vld_q <= '0;
    end else if (w_issue && w_in_shadow) begin
      shadow_q[idx_q]     <= w_dato;
      shadow_vld_q[idx_q] <= 1'b1;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  assign w_issue = (state_q == ST_SEND) && !w_skip;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    w_snap  = 1'b0;
    if ((state_q != ST_IDLE) && start) begin
      pend_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          idx_d   = 5'd0;
          w_snap  = 1'b1;
        end
      end
      ST_SEND: begin
        gap_d = 4'd0;
        if (c_HAS_GAP && !w_skip) begin
          state_d = ST_GAP;
        end else if (idx_q == c_LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 5'd1;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        // A request seen during (or pending from) the sequence chains directly.
        idx_d  = 5'd0;
        pend_d = 1'b0;
        if (pend_q || start) begin
          state_d = ST_SEND;
          w_snap  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      state_q        <= ST_IDLE;
      idx_q          <= 5'd0;
      gap_q          <= 4'd0;
      pend_q         <= 1'b0;
      snap_time_q    <= '0;
      snap_tempo_q   <= 1'b0;
      snap_fmt_q     <= 1'b0;
      snap_cur_q     <= 3'd0;
      snap_prog_q    <= 8'h00;
      write_strobe_q <= 1'b0;
      id_port_q      <= 8'h00;
      dato_q         <= 8'h00;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      if (w_snap) begin
        snap_time_q  <= {agno, messe, giorno, h_oro, m_oro, s_oro, H_run, M_run, S_run};
        snap_tempo_q <= tempo;
        snap_fmt_q   <= formatto;
        snap_cur_q   <= dir_cursor;
        snap_prog_q  <= direccion_prog;
      end
      write_strobe_q <= w_issue;
      if (w_issue) begin
        id_port_q <= w_port;
        dato_q    <= w_dato;
      end
      busy_q <= (state_q != ST_IDLE);
      done_q <= (state_q == ST_FIN);
    end
  end

  assign write_strobe = write_strobe_q;
  assign id_port      = id_port_q;
  assign dato         = dato_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

`default_nettype wire
